ervp_loop_index_streamer: RTL and testbench
===========================================

# ervp_loop_index_streamer

Two-level nested loop sequencer that streams (row, col) index pairs over a valid/ready handshake. It sits directly upstream of the datapath counters: it decides when each loop index advances and when it wraps, and it raises first/last flags. Downstream consumers therefore never drive init/count sequencing themselves. A job is launched by a single start pulse and completes with a one-cycle done pulse.

## Interface
Parameters:
- BW_ROW, 8, width of the row index and of the row bound
- BW_COL, 8, width of the column index and of the column bound
- BW_ADDR, 32, width of the address path (used only with the macro below)

Ports:
- clk  input  1  clock; all logic is on the rising edge
- rstnn  input  1  reset, asynchronous, active-low
- start  input  1  launch pulse; accepted only in IDLE
- clear  input  1  synchronous abort to IDLE
- cfg_row_last  input  BW_ROW  last row index; 0 means 1 row
- cfg_col_last  input  BW_COL  last column index; 0 means 1 column
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse after the final transfer
- o_valid  output  1  index pair available
- o_ready  input  1  consumer accepts the pair
- o_row  output  BW_ROW  current row index
- o_col  output  BW_COL  current column index
- o_first  output  1  o_row==0 && o_col==0
- o_col_last  output  1  o_col==latched col_last
- o_row_last  output  1  o_row==latched row_last
- o_last  output  1  o_col_last && o_row_last

## Operation
- States:
  - IDLE: start -> RUN. On entry to RUN, latch cfg_row_last and cfg_col_last, and set row=col=0.
  - RUN: a transfer occurs when o_valid && o_ready. The final transfer (o_last) -> DONE.
  - DONE: unconditionally -> IDLE after one cycle.
- o_valid is 1 exactly in RUN. o_row, o_col and the flags hold stable while o_valid && !o_ready.
- On each transfer:
  - If !o_col_last: col += 1.
  - Else: col = 0, and row += 1 when !o_row_last.
  - On the final transfer, row and col return to 0.
- Indices never exceed their latched bounds, so there is no width overflow.
- cfg_* inputs are sampled only at start. Changes during RUN are ignored.
- start in RUN or DONE is ignored; it is not queued.
- clear forces IDLE from any state with row=col=0 and no done pulse. clear wins over a simultaneous start or transfer.
- Total transfers per job = (row_last+1)*(col_last+1). Example: 3x4 gives 12 transfers.
- Flags are combinational compares against the registered indices and latched bounds. o_first, o_col_last, o_row_last and o_last are qualified only by the consumer using o_valid.

## Timing
- Reset: state=IDLE, busy=0, done=0, o_valid=0, o_row=0, o_col=0, latched bounds=0, and o_addr=0 when the macro is enabled.
- start sampled at edge T -> busy=1 and o_valid=1 with (0,0) after T.
- Throughput is one pair per cycle when o_ready is held high.
- Final transfer at edge T -> done=1 and o_valid=0 during cycle T+1 -> IDLE and busy=0 at T+2. The earliest next start is accepted at edge T+2.
- Minimum job length (1x1, o_ready=1): start at cycle 0, transfer at cycle 1, done at cycle 2, IDLE at cycle 3.
- Reset asserted mid-job returns to the reset values immediately (asynchronous), with no done pulse.

## Configuration
- Macro: ERVP_LOOP_INDEX_STREAMER_ADDR_EN.
- Defined: adds the following ports:
  - cfg_base (input, BW_ADDR)
  - cfg_row_stride (input, BW_ADDR)
  - cfg_col_stride (input, BW_ADDR)
  - o_addr (output, BW_ADDR)
- Address behaviour with the macro defined:
  - All three cfg values are latched at start, and o_addr=cfg_base at (0,0).
  - On a column-advance transfer: o_addr += col_stride.
  - On a column wrap: the internal row_base += row_stride, and o_addr = new row_base.
  - On the final transfer: o_addr = latched base.
  - Arithmetic is modulo 2^BW_ADDR.
  - Net effect: o_addr = base + row*row_stride + col*col_stride with no multiplier.
  - clear and reset set o_addr and row_base to 0.
- Undefined: the address ports and registers are absent, and index behaviour is identical.

## Test plan
- Basic 3x4: row_last=2, col_last=3, o_ready=1, start at cycle 0 -> 12 consecutive pairs (0,0),(0,1)…(2,3). o_first only on the first pair, o_col_last on col=3, o_last on the 12th pair. done=1 exactly one cycle after the 12th pair.
- Backpressure: 2x2 with o_ready toggling 1,0,0,1… -> pair and flags held while o_ready=0. Exactly 4 transfers, and the order is unchanged.
- Degenerate 1x1: row_last=col_last=0 -> a single pair with o_first=o_last=1, then done on the next cycle.
- Clear mid-job: 4x4, clear asserted after 5 transfers, simultaneously with start -> IDLE next cycle, done never asserted, indices 0. A start 1 cycle later runs a full 16-pair job.
- Ignored inputs: start pulsed and cfg_col_last changed from 3 to 7 during RUN of a 2x4 job -> exactly 8 pairs with col ≤ 3.
- Macro enabled: base=0x1000, row_stride=0x100, col_stride=0x4, 2x3 job -> o_addr sequence 0x1000, 0x1004, 0x1008, 0x1100, 0x1104, 0x1108. Base=0xFFFFFFFC with col_stride=4 wraps to 0x0 on the second pair.

Source files
------------

// File: rtl/ervp_loop_index_streamer.sv
// rtl/ervp_loop_index_streamer.sv - two-level nested (row, col) index streamer with valid/ready output
// Optional address generator enabled by `define ERVP_LOOP_INDEX_STREAMER_ADDR_EN.
module ervp_loop_index_streamer #(
  parameter int BW_ROW  = 8,
  parameter int BW_COL  = 8,
  parameter int BW_ADDR = 32
) (
  input  logic              clk,
  input  logic              rstnn,
  input  logic              start,
  input  logic              clear,
  input  logic [BW_ROW-1:0] cfg_row_last,
  input  logic [BW_COL-1:0] cfg_col_last,
`ifdef ERVP_LOOP_INDEX_STREAMER_ADDR_EN
  input  logic [BW_ADDR-1:0] cfg_base,
  input  logic [BW_ADDR-1:0] cfg_row_stride,
  input  logic [BW_ADDR-1:0] cfg_col_stride,
  output logic [BW_ADDR-1:0] o_addr,
`endif
  output logic              busy,
  output logic              done,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [BW_ROW-1:0] o_row,
  output logic [BW_COL-1:0] o_col,
  output logic              o_first,
  output logic              o_col_last,
  output logic              o_row_last,
  output logic              o_last
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [BW_ROW-1:0] row_q, row_d, row_last_q;
  logic [BW_COL-1:0] col_q, col_d, col_last_q;
  logic              xfer;
  logic              col_hit;
  logic              row_hit;
  logic              last_hit;

  if (BW_ROW < 1 || BW_COL < 1 || BW_ADDR < 1) begin : g_param_check
    $error("ervp_loop_index_streamer: widths must be at least 1");
  end

  assign col_hit  = (col_q == col_last_q);
  assign row_hit  = (row_q == row_last_q);
  assign last_hit = col_hit && row_hit;
  assign xfer     = (state_q == S_RUN) && o_ready;

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign o_valid    = (state_q == S_RUN);
  assign o_row      = row_q;
  assign o_col      = col_q;
  assign o_first    = (row_q == '0) && (col_q == '0);
  assign o_col_last = col_hit;
  assign o_row_last = row_hit;
  assign o_last     = last_hit;

  // Column advances first; on a column wrap the row advances, and the final pair rewinds both.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (xfer) begin
      if (last_hit) begin
        row_d = '0;
        col_d = '0;
      end else if (!col_hit) begin
        col_d = col_q + 1'b1;
      end else begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end
    end
  end

`ifdef ERVP_LOOP_INDEX_STREAMER_ADDR_EN
  logic [BW_ADDR-1:0] addr_q, addr_d;
  logic [BW_ADDR-1:0] row_base_q, row_base_d;
  logic [BW_ADDR-1:0] base_q, row_stride_q, col_stride_q;

  assign o_addr = addr_q;

  // Strength-reduced base + row*row_stride + col*col_stride.
  always_comb begin
    addr_d     = addr_q;
    row_base_d = row_base_q;
    if (xfer) begin
      if (last_hit) begin
        addr_d     = base_q;
        row_base_d = base_q;
      end else if (!col_hit) begin
        addr_d = addr_q + col_stride_q;
      end else begin
        row_base_d = row_base_q + row_stride_q;
        addr_d     = row_base_q + row_stride_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      addr_q       <= '0;
      row_base_q   <= '0;
      base_q       <= '0;
      row_stride_q <= '0;
      col_stride_q <= '0;
    end else if (clear) begin
      addr_q     <= '0;
      row_base_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (start) begin
        addr_q       <= cfg_base;
        row_base_q   <= cfg_base;
        base_q       <= cfg_base;
        row_stride_q <= cfg_row_stride;
        col_stride_q <= cfg_col_stride;
      end
    end else begin
      addr_q     <= addr_d;
      row_base_q <= row_base_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      row_last_q <= '0;
      col_last_q <= '0;
    end else if (clear) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_RUN;
            row_last_q <= cfg_row_last;
            col_last_q <= cfg_col_last;
            row_q      <= '0;
            col_q      <= '0;
          end
        end
        S_RUN: begin
          row_q <= row_d;
          col_q <= col_d;
          if (xfer && last_hit) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ervp_loop_index_streamer.sv
// tb/tb_ervp_loop_index_streamer.sv - scoreboard bench for ervp_loop_index_streamer
module tb_ervp_loop_index_streamer;

  logic        clk = 1'b0;
  logic        rstnn = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic        o_ready = 1'b0;
  logic [7:0]  cfg_row_last = '0;
  logic [7:0]  cfg_col_last = '0;
  logic        busy, done, o_valid, o_first, o_col_last, o_row_last, o_last;
  logic [7:0]  o_row, o_col;
`ifdef ERVP_LOOP_INDEX_STREAMER_ADDR_EN
  logic [31:0] cfg_base = '0;
  logic [31:0] cfg_row_stride = '0;
  logic [31:0] cfg_col_stride = '0;
  logic [31:0] o_addr;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0]  row;
    logic [7:0]  col;
    logic        first;
    logic        col_last;
    logic        row_last;
    logic        last;
    logic [31:0] addr;
  } pair_t;

  typedef struct packed {
    logic  valid;
    logic  done;
    logic  busy;
    logic  xfer;
    pair_t p;
  } obs_t;

  pair_t exp_q[$];

  ervp_loop_index_streamer #(.BW_ROW(8), .BW_COL(8), .BW_ADDR(32)) dut (
    .clk(clk),
    .rstnn(rstnn),
    .start(start),
    .clear(clear),
    .cfg_row_last(cfg_row_last),
    .cfg_col_last(cfg_col_last),
`ifdef ERVP_LOOP_INDEX_STREAMER_ADDR_EN
    .cfg_base(cfg_base),
    .cfg_row_stride(cfg_row_stride),
    .cfg_col_stride(cfg_col_stride),
    .o_addr(o_addr),
`endif
    .busy(busy),
    .done(done),
    .o_valid(o_valid),
    .o_ready(o_ready),
    .o_row(o_row),
    .o_col(o_col),
    .o_first(o_first),
    .o_col_last(o_col_last),
    .o_row_last(o_row_last),
    .o_last(o_last)
  );

  always #5 clk = ~clk;

  function automatic string pstr(input pair_t p);
    return $sformatf("(row=%0d col=%0d first=%0b col_last=%0b row_last=%0b last=%0b addr=%h)",
                     p.row, p.col, p.first, p.col_last, p.row_last, p.last, p.addr);
  endfunction

  task automatic push_job(input int rl, input int cl, input logic [31:0] base,
                          input logic [31:0] rs, input logic [31:0] cs);
    pair_t e;
    for (int r = 0; r <= rl; r++) begin
      for (int c = 0; c <= cl; c++) begin
        e.row      = 8'(r);
        e.col      = 8'(c);
        e.first    = (r == 0) && (c == 0);
        e.col_last = (c == cl);
        e.row_last = (r == rl);
        e.last     = (c == cl) && (r == rl);
`ifdef ERVP_LOOP_INDEX_STREAMER_ADDR_EN
        e.addr     = base + 32'(r) * rs + 32'(c) * cs;
`else
        e.addr     = '0;
`endif
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic observe(output obs_t ob);
    @(negedge clk);
    ob.valid      = o_valid;
    ob.done       = done;
    ob.busy       = busy;
    ob.xfer       = o_valid && o_ready;
    ob.p.row      = o_row;
    ob.p.col      = o_col;
    ob.p.first    = o_first;
    ob.p.col_last = o_col_last;
    ob.p.row_last = o_row_last;
    ob.p.last     = o_last;
`ifdef ERVP_LOOP_INDEX_STREAMER_ADDR_EN
    ob.p.addr     = o_addr;
`else
    ob.p.addr     = '0;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({busy, done, o_valid} !== 3'b000 || o_row !== 8'd0 || o_col !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%0b done=%0b valid=%0b row=%0d col=%0d required all 0",
               busy, done, o_valid, o_row, o_col);
    end
`ifdef ERVP_LOOP_INDEX_STREAMER_ADDR_EN
    checks++;
    if (o_addr !== 32'd0) begin
      errors++;
      $display("FAIL reset_addr: o_addr=%h required 0", o_addr);
    end
`endif
    @(posedge clk);
    #1;
    rstnn = 1'b1;
  endtask

  task automatic test_basic_3x4;
    obs_t ob;
    pair_t e;
    exp_q.delete();
    push_job(2, 3, 32'h0, 32'h0, 32'h0);
    cfg_row_last = 8'd2;
    cfg_col_last = 8'd3;
    o_ready = 1'b1;
    start = 1'b1;
    observe(ob);
    start = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      observe(ob);
      checks++;
      if (!ob.xfer) begin
        errors++;
        $display("FAIL basic_valid cycle %0d: o_valid=%0b required 1", cyc, ob.valid);
      end else begin
        e = exp_q.pop_front();
        if (ob.p !== e) begin
          errors++;
          $display("FAIL basic_pair %0d: got %s required %s", cyc, pstr(ob.p), pstr(e));
        end
      end
    end
    observe(ob);
    checks++;
    if (ob.done !== 1'b1 || ob.valid !== 1'b0 || ob.busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_done: done=%0b valid=%0b busy=%0b required 1 0 1", ob.done, ob.valid, ob.busy);
    end
    observe(ob);
    checks++;
    if (ob.done !== 1'b0 || ob.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: done=%0b busy=%0b required 0 0", ob.done, ob.busy);
    end
  endtask

  task automatic test_backpressure;
    obs_t ob;
    pair_t e;
    int n = 0;
    exp_q.delete();
    push_job(1, 1, 32'h0, 32'h0, 32'h0);
    cfg_row_last = 8'd1;
    cfg_col_last = 8'd1;
    o_ready = 1'b0;
    start = 1'b1;
    observe(ob);
    start = 1'b0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      o_ready = ((k % 4) == 0) || ((k % 4) == 3);
      observe(ob);
      if (ob.valid && exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bp_extra: unexpected valid pair %s", pstr(ob.p));
      end else if (ob.valid) begin
        checks++;
        e = ob.xfer ? exp_q.pop_front() : exp_q[0];
        if (ob.p !== e) begin
          errors++;
          $display("FAIL bp_pair k=%0d ready=%0b: got %s required %s", k, o_ready, pstr(ob.p), pstr(e));
        end
        if (ob.xfer) n++;
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL bp_count: transfers=%0d required 4", n);
    end
    o_ready = 1'b1;
    observe(ob);
    checks++;
    if (ob.done !== 1'b1 || ob.valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_done: done=%0b valid=%0b required 1 0", ob.done, ob.valid);
    end
  endtask

  task automatic test_single;
    obs_t ob;
    pair_t e;
    exp_q.delete();
    push_job(0, 0, 32'h0, 32'h0, 32'h0);
    cfg_row_last = 8'd0;
    cfg_col_last = 8'd0;
    o_ready = 1'b1;
    start = 1'b1;
    observe(ob);
    start = 1'b0;
    observe(ob);
    e = exp_q.pop_front();
    checks++;
    if (!ob.xfer || ob.p !== e) begin
      errors++;
      $display("FAIL single_pair: valid=%0b got %s required valid=1 %s", ob.valid, pstr(ob.p), pstr(e));
    end
    observe(ob);
    checks++;
    if (ob.done !== 1'b1 || ob.valid !== 1'b0) begin
      errors++;
      $display("FAIL single_done: done=%0b valid=%0b required 1 0", ob.done, ob.valid);
    end
    observe(ob);
    checks++;
    if (ob.busy !== 1'b0 || ob.done !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: busy=%0b done=%0b required 0 0", ob.busy, ob.done);
    end
  endtask

  task automatic test_clear;
    obs_t ob;
    pair_t e;
    exp_q.delete();
    push_job(3, 3, 32'h0, 32'h0, 32'h0);
    cfg_row_last = 8'd3;
    cfg_col_last = 8'd3;
    o_ready = 1'b1;
    start = 1'b1;
    observe(ob);
    start = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      observe(ob);
      e = exp_q.pop_front();
      checks++;
      if (!ob.xfer || ob.p !== e) begin
        errors++;
        $display("FAIL clear_pre %0d: valid=%0b got %s required %s", cyc, ob.valid, pstr(ob.p), pstr(e));
      end
    end
    clear = 1'b1;
    start = 1'b1;
    observe(ob);
    clear = 1'b0;
    start = 1'b0;
    observe(ob);
    checks++;
    if ({ob.busy, ob.valid, ob.done} !== 3'b000 || ob.p.row !== 8'd0 || ob.p.col !== 8'd0) begin
      errors++;
      $display("FAIL clear_idle: busy=%0b valid=%0b done=%0b row=%0d col=%0d required 0 0 0 0 0",
               ob.busy, ob.valid, ob.done, ob.p.row, ob.p.col);
    end
    exp_q.delete();
    push_job(3, 3, 32'h0, 32'h0, 32'h0);
    start = 1'b1;
    observe(ob);
    start = 1'b0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      observe(ob);
      checks++;
      if (!ob.xfer) begin
        errors++;
        $display("FAIL clear_rerun_valid %0d: o_valid=%0b required 1", cyc, ob.valid);
      end else begin
        e = exp_q.pop_front();
        if (ob.p !== e) begin
          errors++;
          $display("FAIL clear_rerun_pair %0d: got %s required %s", cyc, pstr(ob.p), pstr(e));
        end
      end
    end
    observe(ob);
    checks++;
    if (ob.done !== 1'b1) begin
      errors++;
      $display("FAIL clear_rerun_done: done=%0b required 1", ob.done);
    end
  endtask

  task automatic test_ignored_inputs;
    obs_t ob;
    pair_t e;
    exp_q.delete();
    push_job(1, 3, 32'h0, 32'h0, 32'h0);
    cfg_row_last = 8'd1;
    cfg_col_last = 8'd3;
    o_ready = 1'b1;
    start = 1'b1;
    observe(ob);
    start = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (cyc == 2) begin
        start = 1'b1;
        cfg_col_last = 8'd7;
      end else begin
        start = 1'b0;
      end
      observe(ob);
      checks++;
      if (!ob.xfer) begin
        errors++;
        $display("FAIL ign_valid %0d: o_valid=%0b required 1", cyc, ob.valid);
      end else begin
        e = exp_q.pop_front();
        if (ob.p !== e) begin
          errors++;
          $display("FAIL ign_pair %0d: got %s required %s", cyc, pstr(ob.p), pstr(e));
        end
      end
    end
    start = 1'b0;
    observe(ob);
    checks++;
    if (ob.done !== 1'b1 || ob.valid !== 1'b0) begin
      errors++;
      $display("FAIL ign_done: done=%0b valid=%0b required 1 0", ob.done, ob.valid);
    end
    for (int cyc = 0; cyc < 2; cyc++) begin
      observe(ob);
      checks++;
      if (ob.busy !== 1'b0) begin
        errors++;
        $display("FAIL ign_not_queued %0d: busy=%0b required 0", cyc, ob.busy);
      end
    end
    cfg_col_last = 8'd3;
  endtask

  task automatic test_addr(input logic [31:0] base, input logic [31:0] rs, input logic [31:0] cs,
                           input int rl, input int cl);
    obs_t ob;
    pair_t e;
    int total;
    total = (rl + 1) * (cl + 1);
    exp_q.delete();
    push_job(rl, cl, base, rs, cs);
`ifdef ERVP_LOOP_INDEX_STREAMER_ADDR_EN
    cfg_base = base;
    cfg_row_stride = rs;
    cfg_col_stride = cs;
`endif
    cfg_row_last = 8'(rl);
    cfg_col_last = 8'(cl);
    o_ready = 1'b1;
    start = 1'b1;
    observe(ob);
    start = 1'b0;
    for (int cyc = 0; cyc < total; cyc++) begin
      observe(ob);
      checks++;
      if (!ob.xfer) begin
        errors++;
        $display("FAIL addr_valid base=%h %0d: o_valid=%0b required 1", base, cyc, ob.valid);
      end else begin
        e = exp_q.pop_front();
        if (ob.p !== e) begin
          errors++;
          $display("FAIL addr_pair base=%h %0d: got %s required %s", base, cyc, pstr(ob.p), pstr(e));
        end
      end
    end
    observe(ob);
    checks++;
    if (ob.done !== 1'b1) begin
      errors++;
      $display("FAIL addr_done base=%h: done=%0b required 1", base, ob.done);
    end
  endtask

  task automatic test_async_reset;
    obs_t ob;
    cfg_row_last = 8'd2;
    cfg_col_last = 8'd3;
    o_ready = 1'b1;
    start = 1'b1;
    observe(ob);
    start = 1'b0;
    for (int cyc = 0; cyc < 3; cyc++) observe(ob);
    #2;
    rstnn = 1'b0;
    #1;
    checks++;
    if ({busy, done, o_valid} !== 3'b000 || o_row !== 8'd0 || o_col !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: busy=%0b done=%0b valid=%0b row=%0d col=%0d required all 0",
               busy, done, o_valid, o_row, o_col);
    end
    @(posedge clk);
    #1;
    rstnn = 1'b1;
    observe(ob);
    checks++;
    if (ob.done !== 1'b0 || ob.busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_nodone: done=%0b busy=%0b required 0 0", ob.done, ob.busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic_3x4();
    test_backpressure();
    test_single();
    test_clear();
    test_ignored_inputs();
    test_addr(32'h0000_1000, 32'h0000_0100, 32'h0000_0004, 1, 2);
    test_addr(32'hFFFF_FFFC, 32'h0000_0010, 32'h0000_0004, 0, 1);
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
